// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: requester side of the instruction memory interface.
// Owns the PC, presents it to a combinational instruction memory, captures the
// returned word into the IF/ID register and handles stall, branch redirect and
// HALT detection (RUN -> DRAIN -> HALTED).
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   to_pc          fetch address (pc register output, no input->output path)
//   instruction    instruction word returned for to_pc
//   stall          hold PC and IF/ID contents
//   branch_taken   redirect to branch_target and flush IF/ID
//   branch_target  redirect address (bit 0 ignored)
//   halt_commit    HALT reached writeback: stop for good
//   if_id_instr    registered instruction
//   if_id_pc_plus2 registered fetch address + PC_STEP
//   if_id_valid    IF/ID holds a real instruction
//   halted         processor stopped; only rst clears it
//
// Optional build macro FETCH_PERF_COUNT_EN adds saturating counters
// fetch_count (valid captures) and stall_count (stalled cycles in RUN).
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] PC_STEP      = 16'd2,
    parameter logic [15:0] HALT_OPCODE  = 16'h0000,
    parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] to_pc,
    input  logic [15:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt_commit,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic [15:0] pc_next_seq;
    logic [15:0] redirect_pc;

    // Modulo-2^16 wrap is the natural behaviour of the 16-bit add.
    assign pc_next_seq = pc_q + PC_STEP;
    assign redirect_pc = branch_target & 16'hFFFE;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        halted_d   = halted_q;

        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    instr_d = BUBBLE_INSTR;
                end else if (!stall) begin
                    instr_d    = instruction;
                    pc_plus2_d = pc_next_seq;
                    valid_d    = 1'b1;
                    // A HALT is captured but fetch stops on its address.
                    if (instruction == HALT_OPCODE) begin
                        state_d = StDrain;
                    end else begin
                        pc_d = pc_next_seq;
                    end
                end
            end
            StDrain: begin
                if (branch_taken) begin
                    // HALT was on a wrong path: resume at the target.
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    instr_d = BUBBLE_INSTR;
                    state_d = StRun;
                end else begin
                    if (!stall) begin
                        valid_d = 1'b0;
                        instr_d = BUBBLE_INSTR;
                    end
                    if (halt_commit) begin
                        // HALTED always presents an empty IF/ID, even if stalled.
                        state_d  = StHalted;
                        halted_d = 1'b1;
                        valid_d  = 1'b0;
                        instr_d  = BUBBLE_INSTR;
                    end
                end
            end
            StHalted: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            instr_q    <= BUBBLE_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign to_pc          = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc_plus2_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_count_q;
    logic [15:0] stall_count_q;
    logic        fetch_inc;
    logic        stall_inc;

    // Valid captures happen only on an unstalled, unredirected RUN cycle.
    assign fetch_inc = (state_q == StRun) && !branch_taken && !stall;
    assign stall_inc = (state_q == StRun) && stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 16'h0000;
            stall_count_q <= 16'h0000;
        end else begin
            if (fetch_inc && (fetch_count_q != 16'hFFFF)) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (stall_inc && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
